mul_sched: RTL and testbench
============================

MUL_SCHED -- requirements
Module: mul_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one multiplier.
REQ-002 SHALL have parameter NUM_ELEMENTS, default 17, operand element count.
REQ-003 SHALL have parameter BIT_LEN, default 17, element MSB index, so each element is signed [BIT_LEN:0].
REQ-004 SHALL have parameter MUL_LATENCY, default 1, range >=1, cycles after mul_a/mul_b update until mul_c is valid.
REQ-005 SHALL have ports, one clock and an asynchronous active-low reset, with IDW = max(1,$clog2(NUM_REQ)):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  [NUM_REQ]  request pending, per requester
- req_ready  out  [NUM_REQ]  request accepted this cycle
- req_a, req_b  in  [NUM_REQ][NUM_ELEMENTS] x signed [BIT_LEN:0]  operands
- mul_a, mul_b  out  [NUM_ELEMENTS] x signed [BIT_LEN:0]  registered operands to the multiplier
- mul_c  in  [NUM_ELEMENTS*2+1] x signed [BIT_LEN:0]  multiplier product
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed
- rsp_id  out  IDW  index of the requester owning the result
- rsp_c  out  [NUM_ELEMENTS*2+1] x signed [BIT_LEN:0]  captured product
- busy  out  1  high whenever state != IDLE

Function
REQ-006 SHALL implement an FSM with states IDLE, WAIT and RESP, and one operation in flight at most.
REQ-007 SHALL, in IDLE with any req_valid set, assert req_ready combinationally for exactly one granted index g and zero for all others.
REQ-008 SHALL pick g by round-robin: the first set req_valid scanning from (last_grant+1) mod NUM_REQ upward with wrap-around.
REQ-009 SHALL, on the accept edge (cycle T), load mul_a<=req_a[g], mul_b<=req_b[g], rsp_id<=g and last_grant<=g, load the wait counter with MUL_LATENCY, and enter WAIT.
REQ-010 SHALL, in WAIT, decrement the counter each cycle and, on the edge where it equals 1, capture rsp_c<=mul_c and enter RESP.
REQ-011 SHALL drive rsp_valid=1 only in RESP, first asserted in cycle T+1+MUL_LATENCY.
REQ-012 SHALL hold rsp_valid, rsp_c and rsp_id stable in RESP until the cycle where rsp_ready=1, then return to IDLE.
REQ-013 SHALL keep req_ready all-zero outside IDLE; the minimum accept-to-accept spacing is MUL_LATENCY+2 cycles.
REQ-014 SHALL treat req_valid dropping before grant as a withdrawn request, with no acknowledgement and no state change.
REQ-015 SHALL hold mul_a, mul_b, rsp_c and rsp_id at their last values when not updating, with no clearing.
REQ-016 SHALL treat NUM_REQ=1 as a degenerate case with a constant grant of 0.

Reset
REQ-017 SHALL, on rst_n low, asynchronously force: state=IDLE, rsp_valid=0, busy=0, req_ready=0, mul_a, mul_b, rsp_c, rsp_id and the wait counter to 0, and last_grant=NUM_REQ-1.
REQ-018 SHALL discard any in-flight operation on reset mid-WAIT or mid-RESP; no response is ever issued for it.

Configuration
REQ-019 SHALL, with macro MUL_SCHED_PERF_EN defined, add outputs perf_ops [31:0] and perf_stall [31:0], both reset to 0 and saturating at all-ones:
- perf_ops increments once per rsp handshake.
- perf_stall increments each cycle with rsp_valid=1 and rsp_ready=0.
REQ-020 SHALL, without MUL_SCHED_PERF_EN, omit those ports and counters entirely; all other behaviour is identical.

Verification
REQ-021 Reset: rst_n low for 3 cycles, then released -> all outputs 0, busy=0; the first grant with req_valid=4'b1111 goes to index 0.
REQ-022 Single op (MUL_LATENCY=1): req_valid[2]=1, a[0]=3, b[0]=-5, rest 0, accepted at T -> rsp_valid at T+2, rsp_id=2, rsp_c equal to the reference multiplier model output for those operands.
REQ-023 Fairness: req_valid=4'b1111 held and rsp_ready=1 -> grant sequence 0,1,2,3,0,1, with accepts spaced 3 cycles apart.
REQ-024 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_c and rsp_id stable, req_ready=0; with MUL_SCHED_PERF_EN, perf_stall=5 and perf_ops=1 after the handshake.
REQ-025 Reset mid-op: rst_n pulsed low during WAIT -> rsp_valid never asserts for that op; the next grant goes to the lowest-index valid requester.
REQ-026 Latency sweep: MUL_LATENCY=3, accept at T -> rsp_c is sampled from mul_c at the end of T+3, and rsp_valid first asserts at T+4.

Source files
------------

// File: rtl/mul_sched.sv
// rtl/mul_sched.sv - round-robin scheduler sharing one multiplier among NUM_REQ requesters
// Optional perf counters (perf_ops, perf_stall) are built when MUL_SCHED_PERF_EN is defined.
module mul_sched #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_ELEMENTS = 17,
  parameter int BIT_LEN      = 17,
  parameter int MUL_LATENCY  = 1,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int NC  = NUM_ELEMENTS * 2 + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic signed [BIT_LEN:0]   req_a [NUM_REQ][NUM_ELEMENTS],
  input  logic signed [BIT_LEN:0]   req_b [NUM_REQ][NUM_ELEMENTS],
  output logic signed [BIT_LEN:0]   mul_a [NUM_ELEMENTS],
  output logic signed [BIT_LEN:0]   mul_b [NUM_ELEMENTS],
  input  logic signed [BIT_LEN:0]   mul_c [NC],
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IDW-1:0]            rsp_id,
  output logic signed [BIT_LEN:0]   rsp_c [NC],
  output logic                      busy
`ifdef MUL_SCHED_PERF_EN
  ,
  output logic [31:0]               perf_ops,
  output logic [31:0]               perf_stall
`endif
);

  localparam int CW = $clog2(MUL_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [IDW-1:0]     last_grant;
  logic [IDW-1:0]     grant_idx;
  logic [IDW-1:0]     scan_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic               found;

  // Scan starts just past the previous winner so every requester gets a turn.
  always_comb begin
    grant_idx = '0;
    scan_idx  = '0;
    found     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = IDW'((int'(last_grant) + 1 + k) % NUM_REQ);
      if (!found && req_valid[scan_idx]) begin
        found     = 1'b1;
        grant_idx = scan_idx;
      end
    end
    grant_oh = found ? (NUM_REQ'(1) << grant_idx) : '0;
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE) req_ready = grant_oh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rsp_valid  <= 1'b0;
      busy       <= 1'b0;
      rsp_id     <= '0;
      cnt        <= '0;
      last_grant <= IDW'(NUM_REQ - 1);
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
        mul_a[i] <= '0;
        mul_b[i] <= '0;
      end
      for (int k = 0; k < NC; k++) rsp_c[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            for (int i = 0; i < NUM_ELEMENTS; i++) begin
              mul_a[i] <= req_a[grant_idx][i];
              mul_b[i] <= req_b[grant_idx][i];
            end
            rsp_id     <= grant_idx;
            last_grant <= grant_idx;
            cnt        <= CW'(MUL_LATENCY);
            busy       <= 1'b1;
            state      <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            for (int k = 0; k < NC; k++) rsp_c[k] <= mul_c[k];
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MUL_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (rsp_valid && rsp_ready && perf_ops != '1) perf_ops <= perf_ops + 32'd1;
      if (rsp_valid && !rsp_ready && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_sched.sv
// tb/tb_mul_sched.sv - directed self-checking bench for mul_sched (latency 1 and latency 3 instances)
module tb_mul_sched;
  localparam int NR = 4;
  localparam int NE = 17;
  localparam int NC = 35;
  localparam int EW = 18;
  localparam int PW = 36;
  localparam int W  = NC * EW;

  typedef logic [NE*EW-1:0] avec_t;
  typedef logic [NC*EW-1:0] cvec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic signed [EW-1:0] req_a [NR][NE];
  logic signed [EW-1:0] req_b [NR][NE];

  logic [NR-1:0] v1, rdy1, v3, rdy3;
  logic signed [EW-1:0] ma1 [NE], mb1 [NE], mc1 [NC], rc1 [NC];
  logic signed [EW-1:0] ma3 [NE], mb3 [NE], mc3 [NC], rc3 [NC];
  logic rv1, rr1, busy1, rv3, rr3, busy3;
  logic [1:0] rid1, rid3;
`ifdef MUL_SCHED_PERF_EN
  logic [31:0] pops1, pstall1, pops3, pstall3;
`endif

  avec_t ma1p, mb1p, ma3p, mb3p;
  cvec_t rc1p, rc3p, c1v, exp_c;
  cvec_t p1 = '0;
  cvec_t p2 = '0;

  int checks = 0;
  int failures = 0;
  int g;

  mul_sched #(.NUM_REQ(NR), .NUM_ELEMENTS(NE), .BIT_LEN(EW-1), .MUL_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(rdy1),
    .req_a(req_a), .req_b(req_b), .mul_a(ma1), .mul_b(mb1), .mul_c(mc1),
    .rsp_valid(rv1), .rsp_ready(rr1), .rsp_id(rid1), .rsp_c(rc1), .busy(busy1)
`ifdef MUL_SCHED_PERF_EN
    , .perf_ops(pops1), .perf_stall(pstall1)
`endif
  );

  mul_sched #(.NUM_REQ(NR), .NUM_ELEMENTS(NE), .BIT_LEN(EW-1), .MUL_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(rdy3),
    .req_a(req_a), .req_b(req_b), .mul_a(ma3), .mul_b(mb3), .mul_c(mc3),
    .rsp_valid(rv3), .rsp_ready(rr3), .rsp_id(rid3), .rsp_c(rc3), .busy(busy3)
`ifdef MUL_SCHED_PERF_EN
    , .perf_ops(pops3), .perf_stall(pstall3)
`endif
  );

  // Reference multiplier: element-wise polynomial product, each term wrapped to EW bits.
  function automatic cvec_t conv(input avec_t a, input avec_t b);
    logic signed [47:0] acc [NC];
    logic signed [EW-1:0] ea, eb;
    logic signed [PW-1:0] p;
    cvec_t r;
    r = '0;
    for (int k = 0; k < NC; k++) acc[k] = '0;
    for (int i = 0; i < NE; i++) begin
      for (int j = 0; j < NE; j++) begin
        ea = a[i*EW +: EW];
        eb = b[j*EW +: EW];
        p = PW'(ea) * PW'(eb);
        acc[i+j] = acc[i+j] + 48'(p);
      end
    end
    for (int k = 0; k < NC; k++) r[k*EW +: EW] = acc[k][EW-1:0];
    return r;
  endfunction

  function automatic avec_t pk_req(input int idx, input bit sel_b);
    avec_t r;
    r = '0;
    for (int i = 0; i < NE; i++) r[i*EW +: EW] = sel_b ? req_b[idx][i] : req_a[idx][i];
    return r;
  endfunction

  always_comb begin
    ma1p = '0; mb1p = '0; ma3p = '0; mb3p = '0; rc1p = '0; rc3p = '0;
    for (int i = 0; i < NE; i++) begin
      ma1p[i*EW +: EW] = ma1[i];
      mb1p[i*EW +: EW] = mb1[i];
      ma3p[i*EW +: EW] = ma3[i];
      mb3p[i*EW +: EW] = mb3[i];
    end
    for (int k = 0; k < NC; k++) begin
      rc1p[k*EW +: EW] = rc1[k];
      rc3p[k*EW +: EW] = rc3[k];
    end
  end

  always_comb begin
    c1v = conv(ma1p, mb1p);
    for (int k = 0; k < NC; k++) begin
      mc1[k] = c1v[k*EW +: EW];
      mc3[k] = p2[k*EW +: EW];
    end
  end

  // Latency-3 multiplier: product appears three cycles after its operands change.
  always_ff @(posedge clk) begin
    p1 <= conv(ma3p, mb3p);
    p2 <= p1;
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ops();
    for (int r = 0; r < NR; r++) begin
      for (int i = 0; i < NE; i++) begin
        req_a[r][i] = '0;
        req_b[r][i] = '0;
      end
    end
  endtask

  initial begin
    v1 = '0; v3 = '0; rr1 = 1'b0; rr3 = 1'b0;
    clr_ops();
    for (int r = 0; r < NR; r++) begin
      req_a[r][0]  = EW'(r + 1);
      req_a[r][16] = EW'(-(r + 2));
      req_b[r][0]  = EW'(2);
      req_b[r][16] = EW'(3);
    end

    // Reset held for three cycles; ready must stay low even with requests pending.
    repeat (3) @(posedge clk);
    #1;
    v1 = 4'b1111;
    #1;
    chk("rdy_in_reset", W'(rdy1), W'(4'b0000));
    chk("busy_in_reset", W'(busy1), W'(1'b0));
    rst_n = 1'b1;
    rr1 = 1'b1;
    #1;
    chk("rst_rsp_valid", W'(rv1), W'(1'b0));
    chk("rst_rsp_id", W'(rid1), W'(2'd0));
    chk("rst_mul_a", W'(ma1p), W'(0));
    chk("rst_rsp_c", rc1p, W'(0));
    chk("rst_busy3", W'(busy3), W'(1'b0));

    // Round-robin over all four requesters, accepts three cycles apart.
    for (int n = 0; n < 6; n++) begin
      g = n % 4;
      chk("fair_grant", W'(rdy1), W'(4'b0001 << g));
      step();
      chk("fair_busy", W'(busy1), W'(1'b1));
      chk("fair_id", W'(rid1), W'(g));
      chk("fair_rdy_wait", W'(rdy1), W'(0));
      chk("fair_mul_a", W'(ma1p), W'(pk_req(g, 1'b0)));
      chk("fair_rv_wait", W'(rv1), W'(1'b0));
      step();
      chk("fair_rv_resp", W'(rv1), W'(1'b1));
      chk("fair_rdy_resp", W'(rdy1), W'(0));
      chk("fair_rsp_c", rc1p, conv(pk_req(g, 1'b0), pk_req(g, 1'b1)));
      step();
    end

    // Reset pulse during WAIT discards the operation.
    chk("pre_rst_grant", W'(rdy1), W'(4'b0100));
    step();
    chk("mid_busy", W'(busy1), W'(1'b1));
    v1 = '0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", W'(busy1), W'(1'b0));
    chk("mid_rst_mul_a", W'(ma1p), W'(0));
    step();
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      chk("no_rsp_after_rst", W'(rv1), W'(1'b0));
    end
    v1 = 4'b0110;
    #1;
    chk("post_rst_grant", W'(rdy1), W'(4'b0010));
    v1 = '0;
    step();
    chk("withdraw_busy", W'(busy1), W'(1'b0));
    chk("withdraw_rdy", W'(rdy1), W'(0));

    // Single op: 3 * -5 on requester 2, then five cycles of backpressure.
    clr_ops();
    req_a[2][0] = 18'sd3;
    req_b[2][0] = -18'sd5;
    exp_c = '0;
    exp_c[0 +: EW] = 18'h3FFF1;
    rr1 = 1'b0;
    v1 = 4'b0100;
    #1;
    chk("single_grant", W'(rdy1), W'(4'b0100));
    step();
    v1 = 4'b1111;
    #1;
    chk("single_rv_t1", W'(rv1), W'(1'b0));
    step();
    for (int n = 0; n < 5; n++) begin
      chk("bp_rv", W'(rv1), W'(1'b1));
      chk("bp_id", W'(rid1), W'(2'd2));
      chk("bp_rsp_c", rc1p, exp_c);
      chk("bp_rdy", W'(rdy1), W'(0));
      step();
    end
    rr1 = 1'b1;
    #1;
    chk("bp_rv_last", W'(rv1), W'(1'b1));
    step();
    v1 = '0;
    chk("bp_done_rv", W'(rv1), W'(1'b0));
`ifdef MUL_SCHED_PERF_EN
    chk("perf_ops", W'(pops1), W'(32'd1));
    chk("perf_stall", W'(pstall1), W'(32'd5));
`endif
    step();

    // Latency 3: product sampled at the end of T+3, valid first seen at T+4.
    clr_ops();
    req_a[0][0] = 18'sd7;
    req_a[0][1] = 18'sd2;
    req_b[0][0] = 18'sd4;
    req_b[0][1] = -18'sd3;
    exp_c = '0;
    exp_c[0*EW +: EW] = 18'h0001C;
    exp_c[1*EW +: EW] = 18'h3FFF3;
    exp_c[2*EW +: EW] = 18'h3FFFA;
    rr3 = 1'b1;
    v3 = 4'b0001;
    #1;
    chk("l3_grant", W'(rdy3), W'(4'b0001));
    step();
    v3 = '0;
    for (int n = 1; n <= 3; n++) begin
      chk("l3_rv_early", W'(rv3), W'(1'b0));
      step();
    end
    chk("l3_rv", W'(rv3), W'(1'b1));
    chk("l3_id", W'(rid3), W'(2'd0));
    chk("l3_rsp_c", rc3p, exp_c);
    step();
    chk("l3_done", W'(busy3), W'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
